// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK
  } state_e;

  localparam logic [1:0] PTR_TEMP    = 2'b00;
  localparam logic [1:0] PTR_CONFIG  = 2'b01;
  localparam logic [1:0] PTR_GENERAL = 2'b10;
  localparam logic [1:0] PTR_DEFAULT = 2'b11;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // 16-bit word presented to the master for a given pointer
  function automatic logic [15:0] rd_word(input logic [1:0]  ptr,
                                          input logic [15:0] temp,
                                          input logic [7:0]  cfg,
                                          input logic [7:0]  gen,
                                          input logic [15:0] dflt);
    case (ptr)
      PTR_TEMP:    return temp;
      PTR_CONFIG:  return {cfg, 8'h00};
      PTR_GENERAL: return {gen, 8'h00};
      PTR_DEFAULT: return dflt;
      default:     return dflt;
    endcase
  endfunction

  // Pointer advance: only the decoded bits wrap, the upper bits are kept
  function automatic logic [7:0] ptr_inc(input logic [7:0] p);
    return {p[7:2], p[1:0] + 2'd1};
  endfunction

endpackage

// File: rtl/i2c_tgt_linesync.sv
// Synchronises SCL/SDA to clk and produces edge and START/STOP pulses.
module i2c_tgt_linesync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;

  // Synchroniser chains plus one history flop per line; idle bus is high
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a four-entry pointer-selected register map.
// Optional feature macro: I2C_TGT_AUTOINC_EN (pointer auto-increment).
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLV_ADDR    = 7'h48,
  parameter logic [15:0] DEFAULT_VAL = 16'h9821,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [15:0] temp_data,
  output logic [7:0]  config_data,
  output logic [7:0]  general_data,
  output logic        wr_stb,
  output logic        busy
);

  logic sda_s, scl_rise, scl_fall, start, stop;

  i2c_tgt_linesync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_linesync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start),
    .stop_o    (stop)
  );

  state_e      state_q;
  logic [2:0]  bitcnt_q;
  logic        byte_full_q;
  logic [7:0]  rx_q, tx_q, ptr_q, cfg_q, gen_q;
  logic [15:0] word_q;
  logic        half_q, idx_q, rw_q;
  logic        sda_oe_q, wr_stb_q, busy_q;

  logic [7:0]  rx_d, next_byte_d;
  logic [15:0] ld_word_d, reload_word_d;
`ifdef I2C_TGT_AUTOINC_EN
  logic [7:0]  ptr_nxt_d;
`endif

  // Next received byte, first read word and the word/byte that follows an ACKed read byte
  always_comb begin
    rx_d      = {rx_q[6:0], sda_s};
    ld_word_d = rd_word(ptr_q[1:0], temp_data, cfg_q, gen_q, DEFAULT_VAL);
`ifdef I2C_TGT_AUTOINC_EN
    ptr_nxt_d     = ptr_inc(ptr_q);
    reload_word_d = rd_word(ptr_nxt_d[1:0], temp_data, cfg_q, gen_q, DEFAULT_VAL);
`else
    reload_word_d = word_q;
`endif
    next_byte_d = half_q ? reload_word_d[15:8] : word_q[7:0];
  end

  // Protocol FSM and register file; SDA drive only updates on SCL falling edges
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= 3'd7;
      byte_full_q <= 1'b0;
      rx_q        <= '0;
      tx_q        <= '0;
      ptr_q       <= '0;
      cfg_q       <= '0;
      gen_q       <= '0;
      word_q      <= '0;
      half_q      <= 1'b0;
      idx_q       <= 1'b0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      wr_stb_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      wr_stb_q <= 1'b0;
      if (start) begin
        state_q     <= ST_ADDR;
        bitcnt_q    <= 3'd7;
        byte_full_q <= 1'b0;
        busy_q      <= 1'b1;
        sda_oe_q    <= 1'b0;
      end else if (stop) begin
        state_q     <= ST_IDLE;
        byte_full_q <= 1'b0;
        busy_q      <= 1'b0;
        sda_oe_q    <= 1'b0;
      end else begin
        case (state_q)
          // Address and write data share the receive shifter; the byte is
          // acted on at the falling edge after its 8th bit so a STOP mid-byte
          // never reaches the registers
          ST_ADDR, ST_WR_BYTE: begin
            if (scl_rise) begin
              rx_q     <= rx_d;
              bitcnt_q <= bitcnt_q - 3'd1;
              if (bitcnt_q == 3'd0) byte_full_q <= 1'b1;
            end else if (scl_fall && byte_full_q) begin
              byte_full_q <= 1'b0;
              if (state_q == ST_ADDR) begin
                if (rx_q[7:1] == SLV_ADDR) begin
                  state_q  <= ST_ADDR_ACK;
                  rw_q     <= rx_q[0];
                  sda_oe_q <= 1'b1;
                end else begin
                  state_q <= ST_IDLE;
                end
              end else begin
                state_q  <= ST_WR_ACK;
                sda_oe_q <= 1'b1;
                idx_q    <= 1'b1;
                if (!idx_q) begin
                  ptr_q <= rx_q;
                end else begin
                  case (ptr_q[1:0])
                    PTR_CONFIG: begin
                      cfg_q    <= rx_q;
                      wr_stb_q <= 1'b1;
                    end
                    PTR_GENERAL: begin
                      gen_q    <= rx_q;
                      wr_stb_q <= 1'b1;
                    end
                    default: ;
                  endcase
`ifdef I2C_TGT_AUTOINC_EN
                  ptr_q <= ptr_nxt_d;
`endif
                end
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              bitcnt_q <= 3'd7;
              if (rw_q) begin
                state_q  <= ST_RD_BYTE;
                word_q   <= ld_word_d;
                half_q   <= 1'b0;
                tx_q     <= ld_word_d[15:8];
                sda_oe_q <= ~ld_word_d[15];
              end else begin
                state_q  <= ST_WR_BYTE;
                idx_q    <= 1'b0;
                sda_oe_q <= 1'b0;
              end
            end
          end
          ST_WR_ACK: begin
            if (scl_fall) begin
              state_q  <= ST_WR_BYTE;
              bitcnt_q <= 3'd7;
              sda_oe_q <= 1'b0;
            end
          end
          ST_RD_BYTE: begin
            if (scl_rise) begin
              bitcnt_q <= bitcnt_q - 3'd1;
              if (bitcnt_q == 3'd0) byte_full_q <= 1'b1;
            end else if (scl_fall) begin
              if (byte_full_q) begin
                byte_full_q <= 1'b0;
                state_q     <= ST_RD_ACK;
                sda_oe_q    <= 1'b0;
              end else begin
                tx_q     <= {tx_q[6:0], 1'b0};
                sda_oe_q <= ~tx_q[6];
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              if (sda_s == NACK) state_q <= ST_IDLE;
            end else if (scl_fall) begin
              state_q  <= ST_RD_BYTE;
              bitcnt_q <= 3'd7;
              half_q   <= ~half_q;
              tx_q     <= next_byte_d;
              sda_oe_q <= ~next_byte_d[7];
`ifdef I2C_TGT_AUTOINC_EN
              if (half_q) begin
                ptr_q  <= ptr_nxt_d;
                word_q <= reload_word_d;
              end
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe       = sda_oe_q;
  assign config_data  = cfg_q;
  assign general_data = gen_q;
  assign wr_stb       = wr_stb_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master plus a register-map model.
`timescale 1ns/1ps
module tb_i2c_target_regs;

`ifdef I2C_TGT_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  localparam int Q = 6;  // clk cycles per quarter SCL period

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1, sda_m = 1'b1;
  logic        sda_oe;
  logic [15:0] temp_data = 16'h0000;
  logic [7:0]  config_data, general_data;
  logic        wr_stb, busy;
  logic        sda_line;

  assign sda_line = sda_m & ~sda_oe;

  i2c_target_regs #(
    .SLV_ADDR   (7'h48),
    .DEFAULT_VAL(16'h9821),
    .SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .scl_i       (scl_m),
    .sda_i       (sda_line),
    .sda_oe      (sda_oe),
    .temp_data   (temp_data),
    .config_data (config_data),
    .general_data(general_data),
    .wr_stb      (wr_stb),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int stb_cnt = 0;
  bit oe_seen = 1'b0;
  logic oe_prev = 1'b0, scl_prev = 1'b1, rst_prev = 1'b1;

  // reference model state
  logic [7:0] m_ptr = 8'h00, m_cfg = 8'h00, m_gen = 8'h00;
  int         m_stb = 0;
  logic [7:0] wq[$];
  logic [7:0] rq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // strobe counter, SDA activity flag, and SDA-stable-while-SCL-high monitor
  always @(negedge clk) begin
    if (wr_stb === 1'b1) stb_cnt++;
    if (sda_oe === 1'b1) oe_seen = 1'b1;
    if (!rst && !rst_prev && scl_m && scl_prev) check("oe_stable_scl_hi", sda_oe, oe_prev);
    oe_prev  = sda_oe;
    scl_prev = scl_m;
    rst_prev = rst;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: run exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] m_word(input logic [7:0] p);
    case (p[1:0])
      2'd0:    return temp_data;
      2'd1:    return {m_cfg, 8'h00};
      2'd2:    return {m_gen, 8'h00};
      default: return 16'h9821;
    endcase
  endfunction

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b0; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b1; qwait();
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; qwait();
    scl_m = 1'b1; qwait(); qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    b = sda_line; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic get_byte(output logic [7:0] d, input logic ackbit);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(ackbit);
  endtask

  // write transfer to 0x48: wq holds pointer byte then data bytes
  task automatic xfer_write(input string tag);
    logic a;
    int   s0, e0;
    s0 = stb_cnt;
    e0 = m_stb;
    bus_start();
    check({tag, "_busy_hi"}, busy, 1'b1);
    put_byte(8'h90, a);
    check({tag, "_aack"}, a, 1'b0);
    for (int i = 0; i < wq.size(); i++) begin
      put_byte(wq[i], a);
      check($sformatf("%s_wack%0d", tag, i), a, 1'b0);
      if (i == 0) m_ptr = wq[i];
      else begin
        if (m_ptr[1:0] == 2'd1) begin m_cfg = wq[i]; m_stb++; end
        if (m_ptr[1:0] == 2'd2) begin m_gen = wq[i]; m_stb++; end
        if (AUTOINC) m_ptr = {m_ptr[7:2], m_ptr[1:0] + 2'd1};
      end
    end
    bus_stop();
    repeat (4) @(negedge clk);
    check({tag, "_busy_lo"}, busy, 1'b0);
    check({tag, "_cfg"}, config_data, m_cfg);
    check({tag, "_gen"}, general_data, m_gen);
    check({tag, "_stb"}, stb_cnt - s0, m_stb - e0);
  endtask

  // read transfer of n bytes; all ACKed except the last
  task automatic xfer_read(input string tag, input int unsigned n);
    logic a;
    logic [7:0]  b, e;
    logic [15:0] w;
    rq.delete();
    bus_start();
    put_byte(8'h91, a);
    check({tag, "_aack"}, a, 1'b0);
    for (int unsigned k = 0; k < n; k++) begin
      w = m_word(m_ptr);
      e = k[0] ? w[7:0] : w[15:8];
      get_byte(b, (k == n - 1));
      rq.push_back(b);
      check($sformatf("%s_rd%0d", tag, k), b, e);
      if (AUTOINC && k[0] && (k != n - 1)) m_ptr = {m_ptr[7:2], m_ptr[1:0] + 2'd1};
    end
    repeat (2) @(negedge clk);
    check({tag, "_oe_nack"}, sda_oe, 1'b0);
    bus_stop();
    repeat (4) @(negedge clk);
    check({tag, "_busy_lo"}, busy, 1'b0);
  endtask

  initial begin
    logic a;
    logic [7:0] tmp;
    repeat (5) @(negedge clk);
    check("rst_oe", sda_oe, 1'b0);
    check("rst_cfg", config_data, 8'h00);
    check("rst_gen", general_data, 8'h00);
    check("rst_stb", wr_stb, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // T1: write config
    wq = '{8'h01, 8'hA5};
    xfer_write("t1");
    check("t1_cfg_lit", config_data, 8'hA5);

    // T2: temperature read
    temp_data = 16'h1234;
    wq = '{8'h00};
    xfer_write("t2w");
    xfer_read("t2", 2);
    check("t2_b0_lit", rq[0], 8'h12);
    check("t2_b1_lit", rq[1], 8'h34);

    // T3: config and default reads
    wq = '{8'h01};
    xfer_write("t3w1");
    xfer_read("t3r1", 2);
    check("t3_cfg_msb_lit", rq[0], 8'hA5);
    check("t3_cfg_lsb_lit", rq[1], 8'h00);
    wq = '{8'h03};
    xfer_write("t3w3");
    xfer_read("t3r3", 2);
    check("t3_dflt_msb_lit", rq[0], 8'h98);
    check("t3_dflt_lsb_lit", rq[1], 8'h21);

    // T4: foreign address is ignored and never ACKed
    oe_seen = 1'b0;
    tmp = stb_cnt[7:0];
    bus_start();
    put_byte(8'h44, a);
    check("t4_nack_addr", a, 1'b1);
    put_byte(8'h01, a);
    check("t4_nack_d0", a, 1'b1);
    put_byte(8'h5A, a);
    bus_stop();
    repeat (4) @(negedge clk);
    check("t4_oe_never", oe_seen, 1'b0);
    check("t4_cfg", config_data, m_cfg);
    check("t4_gen", general_data, m_gen);
    check("t4_stb", stb_cnt[7:0], tmp);
    check("t4_busy_lo", busy, 1'b0);

    // T6: multi-byte write (placed before the reset test so it sees live regs)
    wq = '{8'h01, 8'h11, 8'h22};
    xfer_write("t6");
    if (AUTOINC) begin
      check("t6_cfg_lit", config_data, 8'h11);
      check("t6_gen_lit", general_data, 8'h22);
    end else begin
      check("t6_cfg_lit", config_data, 8'h22);
    end

    // T5a: STOP after 4 bits of a data byte
    tmp = stb_cnt[7:0];
    bus_start();
    put_byte(8'h90, a);
    check("t5_aack", a, 1'b0);
    put_byte(8'h02, a);
    check("t5_pack", a, 1'b0);
    m_ptr = 8'h02;
    put_bit(1'b1); put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
    bus_stop();
    repeat (4) @(negedge clk);
    check("t5_gen_keep", general_data, m_gen);
    check("t5_cfg_keep", config_data, m_cfg);
    check("t5_stb_none", stb_cnt[7:0], tmp);
    check("t5_busy_lo", busy, 1'b0);
    check("t5_oe_lo", sda_oe, 1'b0);
    xfer_read("t5r", 2);  // general word, proves FSM recovered

    // T5b: reset in the middle of a read while the target drives SDA low
    temp_data = 16'h0000;
    wq = '{8'h00};
    xfer_write("t5bw");
    bus_start();
    put_byte(8'h91, a);
    check("t5b_aack", a, 1'b0);
    get_bit(a); get_bit(a); get_bit(a);
    check("t5b_oe_driving", sda_oe, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5b_oe_rel", sda_oe, 1'b0);
    check("t5b_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_ptr = 8'h00; m_cfg = 8'h00; m_gen = 8'h00;
    scl_m = 1'b1; qwait();
    sda_m = 1'b1; qwait();
    check("t5b_cfg", config_data, 8'h00);
    check("t5b_gen", general_data, 8'h00);
    check("t5b_busy_idle", busy, 1'b0);

    // Randomised transfers against the model
    for (int it = 0; it < 24; it++) begin
      temp_data = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        wq.delete();
        wq.push_back(8'($urandom_range(0, 255)));
        for (int j = 0; j < int'($urandom_range(0, 3)); j++) wq.push_back(8'($urandom));
        xfer_write($sformatf("rw%0d", it));
      end else begin
        xfer_read($sformatf("rr%0d", it), $urandom_range(1, 4));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
